poly_horner_sequencer: RTL and testbench



---
 rtl/poly_pkg.sv | 24 ++
 rtl/poly_alu.sv | 33 +++
 rtl/poly_horner_sequencer.sv | 148 ++++++++++++++
 tb/tb_poly_horner_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_pkg.sv
// Shared encodings for the Horner polynomial sequencer: FSM states, ALU ops, operand selects.
package poly_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEAD = 3'd1,
    S_COEF = 3'd2,
    S_MUL  = 3'd3,
    S_ADD  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } alu_op_e;

  typedef enum logic [1:0] {
    SEL_ACC  = 2'd0,
    SEL_X    = 2'd1,
    SEL_CREG = 2'd2
  } sel_e;

endpackage

// File: rtl/poly_alu.sv
// Combinational unsigned add/multiply; result truncated to DATA_W, carry flags lost upper bits.
module poly_alu
  import poly_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  alu_op_e           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o,
  output logic              carry_o
);

  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;
  logic [2*DATA_W-1:0] full;

  assign a_ext = {{DATA_W{1'b0}}, a_i};
  assign b_ext = {{DATA_W{1'b0}}, b_i};

  always_comb begin
    full = '0;
    case (op_i)
      OP_ADD:  full = a_ext + b_ext;
      OP_MUL:  full = a_ext * b_ext;
      default: full = '0;
    endcase
  end

  assign y_o     = full[DATA_W-1:0];
  assign carry_o = |full[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/poly_horner_sequencer.sv
// Evaluates p(x) by Horner's method over a shared add/mul ALU; x then c_N..c_0 in, p(x) out.
// Optional sticky overflow flag port enabled by defining POLY_OVF_EN.
module poly_horner_sequencer
  import poly_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEGREE = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
`ifdef POLY_OVF_EN
  ,output logic             ovf
`endif
);

  localparam int IDX_W = (DEGREE > 0) ? $clog2(DEGREE + 1) : 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] creg_q, creg_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  alu_op_e           alu_op;
  sel_e              a_sel, b_sel;
  logic [DATA_W-1:0] alu_a, alu_b, alu_y;
  logic              alu_carry;
  logic              beat;

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_LEAD) || (state_q == S_COEF);
  assign beat      = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign out_data  = res_q;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    case (a_sel)
      SEL_X:    alu_a = x_q;
      SEL_CREG: alu_a = creg_q;
      default:  alu_a = acc_q;
    endcase
    case (b_sel)
      SEL_ACC:  alu_b = acc_q;
      SEL_X:    alu_b = x_q;
      default:  alu_b = creg_q;
    endcase
  end

  poly_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i    (alu_op),
    .a_i     (alu_a),
    .b_i     (alu_b),
    .y_o     (alu_y),
    .carry_o (alu_carry)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    creg_d  = creg_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    alu_op  = OP_ADD;
    a_sel   = SEL_ACC;
    b_sel   = SEL_CREG;
    case (state_q)
      S_IDLE: if (beat) begin
        x_d     = in_data;
        idx_d   = IDX_W'(DEGREE);
        state_d = S_LEAD;
      end
      S_LEAD: if (beat) begin
        acc_d   = in_data;
        state_d = (idx_q == '0) ? S_DONE : S_COEF;
      end
      S_COEF: if (beat) begin
        creg_d  = in_data;
        idx_d   = idx_q - 1'b1;
        state_d = S_MUL;
      end
      S_MUL: begin
        alu_op  = OP_MUL;
        b_sel   = SEL_X;
        acc_d   = alu_y;
        state_d = S_ADD;
      end
      S_ADD: begin
        acc_d   = alu_y;
        state_d = (idx_q == '0) ? S_DONE : S_COEF;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Result is captured on entry to S_DONE so the display keeps it while the next run loads acc.
  always_comb begin
    res_d = res_q;
    if (state_d == S_DONE && state_q != S_DONE) res_d = acc_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      creg_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      creg_q  <= creg_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
    end
  end

`ifdef POLY_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_IDLE && beat) ovf_d = 1'b0;
    else if ((state_q == S_MUL || state_q == S_ADD) && alu_carry) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_alu_carry;
  assign unused_alu_carry = alu_carry;
`endif

endmodule

// File: tb/tb_poly_horner_sequencer.sv
// Directed bench for poly_horner_sequencer: DEGREE=2 main instance plus a DEGREE=0 instance.
module tb_poly_horner_sequencer;
  import poly_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0] out_data;
  logic [7:0] in_data0;
  logic       in_valid0, in_ready0, out_valid0, out_ready0, busy0;
  logic [7:0] out_data0;
`ifdef POLY_OVF_EN
  logic       ovf, ovf0;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit tmo = 1'b0;

  always #5 clk = ~clk;

  poly_horner_sequencer #(.DATA_W(8), .DEGREE(2)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
`ifdef POLY_OVF_EN
    ,.ovf(ovf)
`endif
  );

  poly_horner_sequencer #(.DATA_W(8), .DEGREE(0)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
    .out_ready(out_ready0), .busy(busy0)
`ifdef POLY_OVF_EN
    ,.ovf(ovf0)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one beat and holds it until accepted; sets tmo if never accepted.
  task automatic send(input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) tmo = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) tmo = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    in_valid0 = 1'b0; in_data0 = 8'h00; out_ready0 = 1'b1;
    step(); step();
    reset = 1'b0;
    vectors++;
    if ({busy, in_ready, out_valid, out_data} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset: busy/rdy/vld/data=%b/%b/%b/%h want 0/1/0/00", busy, in_ready, out_valid, out_data);
    end
`ifdef POLY_OVF_EN
    vectors++;
    if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(8'd3); send(8'd1); send(8'd2); send(8'd4);
    vectors++;
    if ({out_valid, in_ready, busy} !== 3'b001) begin
      miscompares++; $display("FAIL basic_T+1: vld/rdy/busy=%b%b%b want 001", out_valid, in_ready, busy);
    end
    step();
    vectors++;
    if ({out_valid, in_ready} !== 2'b00) begin
      miscompares++; $display("FAIL basic_T+2: vld/rdy=%b%b want 00", out_valid, in_ready);
    end
    step();
    vectors++;
    if ({out_valid, out_data} !== {1'b1, 8'h13}) begin
      miscompares++; $display("FAIL basic_T+3: vld=%b data=%h want 1/13", out_valid, out_data);
    end
    step();
    vectors++;
    if ({out_valid, in_ready, busy, out_data} !== {1'b0, 1'b1, 1'b0, 8'h13}) begin
      miscompares++;
      $display("FAIL basic_after: vld/rdy/busy=%b%b%b data=%h want 010/13", out_valid, in_ready, busy, out_data);
    end
    vectors++;
    if (tmo !== 1'b0) begin miscompares++; $display("FAIL basic_timeout: got %b want 0", tmo); end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    send(8'd16); send(8'd1); send(8'd0); send(8'd5);
    wait_valid();
    vectors++;
    if (out_data !== 8'h05) begin miscompares++; $display("FAIL wrap_data: got %h want 05", out_data); end
`ifdef POLY_OVF_EN
    vectors++;
    if (ovf !== 1'b1) begin miscompares++; $display("FAIL wrap_ovf: got %b want 1", ovf); end
`endif
    step();
    send(8'd2); send(8'd1); send(8'd1); send(8'd1);
    wait_valid();
    vectors++;
    if (out_data !== 8'h07) begin miscompares++; $display("FAIL wrap2_data: got %h want 07", out_data); end
`ifdef POLY_OVF_EN
    vectors++;
    if (ovf !== 1'b0) begin miscompares++; $display("FAIL wrap2_ovf: got %b want 0", ovf); end
`endif
    step();
    vectors++;
    if (tmo !== 1'b0) begin miscompares++; $display("FAIL wrap_timeout: got %b want 0", tmo); end
  endtask

  task automatic test_gaps();
    out_ready = 1'b1;
    send(8'd3);
    step();
    vectors++;
    if ({busy, in_ready} !== 2'b11) begin
      miscompares++; $display("FAIL gap_hold: busy/rdy=%b%b want 11", busy, in_ready);
    end
    send(8'd1);
    step();
    send(8'd2);
    in_valid = 1'b1; in_data = 8'hFF;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL gap_mul_rdy: got %b want 0", in_ready); end
    step();
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL gap_add_rdy: got %b want 0", in_ready); end
    step();
    in_data = 8'd4;
    step();
    in_valid = 1'b0;
    wait_valid();
    vectors++;
    if (out_data !== 8'h13) begin miscompares++; $display("FAIL gap_data: got %h want 13", out_data); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(8'd3); send(8'd1); send(8'd2); send(8'd4);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({out_valid, out_data, in_ready} !== {1'b1, 8'h13, 1'b0}) begin
        miscompares++;
        $display("FAIL bp_hold%0d: vld=%b data=%h rdy=%b want 1/13/0", i, out_valid, out_data, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    vectors++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      miscompares++; $display("FAIL bp_release: vld/rdy/busy=%b%b%b want 010", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(8'd5); send(8'd7); send(8'd9);
    vectors++;
    if ({busy, in_ready} !== 2'b10) begin
      miscompares++; $display("FAIL rst_mid_pre: busy/rdy=%b%b want 10", busy, in_ready);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if ({busy, in_ready, out_valid, out_data} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL rst_mid: busy/rdy/vld/data=%b%b%b/%h want 010/00", busy, in_ready, out_valid, out_data);
    end
    send(8'd1); send(8'd1); send(8'd1); send(8'd1);
    wait_valid();
    vectors++;
    if (out_data !== 8'h03) begin miscompares++; $display("FAIL rst_mid_run: got %h want 03", out_data); end
    step();
    vectors++;
    if (tmo !== 1'b0) begin miscompares++; $display("FAIL rst_mid_timeout: got %b want 0", tmo); end
  endtask

  task automatic test_degree0();
    out_ready0 = 1'b1;
    in_valid0 = 1'b1; in_data0 = 8'd9;
    step();
    in_data0 = 8'h2A;
    vectors++;
    if ({in_ready0, busy0} !== 2'b11) begin
      miscompares++; $display("FAIL deg0_lead: rdy/busy=%b%b want 11", in_ready0, busy0);
    end
    step();
    in_valid0 = 1'b0;
    vectors++;
    if ({out_valid0, out_data0, in_ready0} !== {1'b1, 8'h2A, 1'b0}) begin
      miscompares++;
      $display("FAIL deg0_out: vld=%b data=%h rdy=%b want 1/2a/0", out_valid0, out_data0, in_ready0);
    end
`ifdef POLY_OVF_EN
    vectors++;
    if (ovf0 !== 1'b0) begin miscompares++; $display("FAIL deg0_ovf: got %b want 0", ovf0); end
`endif
    step();
    vectors++;
    if ({out_valid0, busy0, out_data0} !== {1'b0, 1'b0, 8'h2A}) begin
      miscompares++; $display("FAIL deg0_after: vld/busy=%b%b data=%h want 00/2a", out_valid0, busy0, out_data0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_gaps();
    test_backpressure();
    test_reset_mid();
    test_degree0();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
